// File: rtl/sim_clock_scheduler_pkg.sv
// sim_clock_scheduler_pkg
//   Shared types and helpers for the clock-enable scheduler.
//   - state_e     : scheduler sequencing states
//   - MIN_DIV     : smallest legal period (a period of 1 has no low phase)
//   - clamp_div   : P   = max(div, MIN_DIV)
//   - clamp_phase : phi = min(phase, P-1)
//   The helpers work on 32-bit values. Callers zero-extend their operands and
//   truncate the result, so any DIV_W up to 32 bits can use them.
package sim_clock_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    STOP = 2'd3
  } state_e;

  localparam int unsigned MIN_DIV = 2;

  function automatic logic [31:0] clamp_div(input logic [31:0] div);
    return (div < MIN_DIV) ? MIN_DIV : div;
  endfunction

  function automatic logic [31:0] clamp_phase(input logic [31:0] phase,
                                              input logic [31:0] p);
    return (phase >= p) ? (p - 32'd1) : phase;
  endfunction

endpackage

// File: rtl/sim_clock_scheduler_chan.sv
// sim_clock_scheduler_chan
//   One scheduler channel. It holds the period counter, the active and shadow
//   {div, phase} configuration, the frozen flag and the registered ce/clk
//   outputs.
//   Optional macro SIM_CLOCK_SCHEDULER_CNT_EN adds a 32-bit count of ce strobes.
// Ports:
//   clk, rst      : base clock, synchronous active-high reset
//   arm           : load counter with phase (one cycle before the first run)
//   run           : free-running count
//   drain         : count until next wrap, then freeze
//   write         : config write for this channel (wr_div/wr_phase pre-clamped)
//   ce, clk_out   : registered strobe (counter==P-1) and toggle (counter<P/2)
//   frozen        : channel has finished draining
//   ce_count      : (optional) strobes since last reset/arm
module sim_clock_scheduler_chan
  import sim_clock_scheduler_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,
  input  logic             run,
  input  logic             drain,
  input  logic             write,
  input  logic [DIV_W-1:0] wr_div,
  input  logic [DIV_W-1:0] wr_phase,
  output logic             ce,
  output logic             clk_out,
  output logic             frozen
`ifdef SIM_CLOCK_SCHEDULER_CNT_EN
  ,
  output logic [31:0]      ce_count
`endif
);

  logic [DIV_W-1:0] cnt, div_act, ph_act, div_sh, ph_sh;
  logic [DIV_W-1:0] cnt_inc, div_last, half;
  logic             wrap, idle_st;

  assign cnt_inc  = cnt + DIV_W'(1);
  assign div_last = div_act - DIV_W'(1);
  assign half     = div_act >> 1;
  assign wrap     = (cnt == div_last);
  assign idle_st  = !(arm || run || drain);

  // The outputs are computed from the counter's next value. This keeps ce and
  // clk_out aligned with the counter they describe in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      div_act <= DIV_W'(MIN_DIV);
      ph_act  <= '0;
      div_sh  <= DIV_W'(MIN_DIV);
      ph_sh   <= '0;
      frozen  <= 1'b0;
      ce      <= 1'b0;
      clk_out <= 1'b0;
    end else begin
      if (write) begin
        div_sh <= wr_div;
        ph_sh  <= wr_phase;
      end
      // While stopped there is no period in flight, so a write goes live at once.
      if (write && idle_st) begin
        div_act <= wr_div;
        ph_act  <= wr_phase;
      end

      if (arm) begin
        cnt     <= ph_act;
        frozen  <= 1'b0;
        ce      <= (ph_act == div_last);
        clk_out <= (ph_act < half);
      end else if ((run || drain) && !frozen) begin
        if (wrap) begin
          // Period boundary: pick up the shadow config. Because P>=2, counter 0
          // is never the last count, and it is always in the high half.
          cnt     <= '0;
          div_act <= div_sh;
          ph_act  <= ph_sh;
          ce      <= 1'b0;
          clk_out <= !drain;
          frozen  <= drain;
        end else begin
          cnt     <= cnt_inc;
          ce      <= (cnt_inc == div_last);
          clk_out <= (cnt_inc < half);
        end
      end else if (drain) begin
        // The channel is frozen while others still drain. Track late shadow
        // writes so the next arm sees them.
        div_act <= div_sh;
        ph_act  <= ph_sh;
      end
    end
  end

`ifdef SIM_CLOCK_SCHEDULER_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || arm)
      ce_count <= '0;
    else if ((run || drain) && ce)
      ce_count <= ce_count + 32'd1;
  end
`endif

endmodule

// File: rtl/sim_clock_scheduler.sv
// sim_clock_scheduler
//   Derives N_OUT clock-enable strobes plus 50%-style toggles from sys_clk.
//   Each channel has its own period and phase. Start and stop are sequenced
//   (IDLE -> ARM -> RUN -> STOP -> IDLE), so no truncated pulse is produced.
//   Optional macro SIM_CLOCK_SCHEDULER_CNT_EN adds ce_count (32 bits/channel).
// Ports:
//   sys_clk, sys_rst           : base clock, synchronous active-high reset
//   cfg_we/cfg_sel/cfg_div/    : per-channel config write (clamped on write;
//   cfg_phase                    a cfg_sel value >= N_OUT is ignored)
//   start, stop                : one-cycle sequencing requests
//   running, idle              : state flags
//   ce_out, clk_out            : per-channel strobe and toggle
//   ce_count                   : (optional) per-channel strobe counts
module sim_clock_scheduler
  import sim_clock_scheduler_pkg::*;
#(
  parameter  int N_OUT = 4,
  parameter  int DIV_W = 16,
  localparam int SEL_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               cfg_we,
  input  logic [SEL_W-1:0]   cfg_sel,
  input  logic [DIV_W-1:0]   cfg_div,
  input  logic [DIV_W-1:0]   cfg_phase,
  input  logic               start,
  input  logic               stop,
  output logic               running,
  output logic               idle,
  output logic [N_OUT-1:0]   ce_out,
  output logic [N_OUT-1:0]   clk_out
`ifdef SIM_CLOCK_SCHEDULER_CNT_EN
  ,
  output logic [N_OUT*32-1:0] ce_count
`endif
);

  state_e           state, state_nxt;
  logic [N_OUT-1:0] en_mask, frozen;
  logic [DIV_W-1:0] wr_div, wr_phase;
  logic             all_frozen;

  // Clamping happens once here and is shared by every channel.
  assign wr_div   = DIV_W'(clamp_div(32'(cfg_div)));
  assign wr_phase = DIV_W'(clamp_phase(32'(cfg_phase), 32'(wr_div)));

  // Channel enable mask. It has no write path, so every channel takes part.
  // A masked channel would count as already frozen.
  always_ff @(posedge sys_clk) begin
    if (sys_rst)
      en_mask <= '1;
  end

  assign all_frozen = &(frozen | ~en_mask);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    running   = 1'b0;
    idle      = 1'b0;
    case (state)
      IDLE: begin
        idle = 1'b1;
        if (start) state_nxt = ARM;   // start wins over a coincident stop
      end
      ARM: begin
        running   = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        running = 1'b1;
        if (stop) state_nxt = STOP;
      end
      STOP: begin
        running = 1'b1;
        if (all_frozen) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  for (genvar i = 0; i < N_OUT; i++) begin : g_chan
    // A match against an index below N_OUT means out-of-range selects are
    // dropped without any explicit range check.
    logic wr;
    assign wr = cfg_we && (cfg_sel == SEL_W'(i));

    sim_clock_scheduler_chan #(.DIV_W(DIV_W)) u_chan (
      .clk      (sys_clk),
      .rst      (sys_rst),
      .arm      ((state == ARM)  && en_mask[i]),
      .run      ((state == RUN)  && en_mask[i]),
      .drain    ((state == STOP) && en_mask[i]),
      .write    (wr),
      .wr_div   (wr_div),
      .wr_phase (wr_phase),
      .ce       (ce_out[i]),
      .clk_out  (clk_out[i]),
      .frozen   (frozen[i])
`ifdef SIM_CLOCK_SCHEDULER_CNT_EN
      ,
      .ce_count (ce_count[i*32 +: 32])
`endif
    );
  end

endmodule

// File: tb/tb_sim_clock_scheduler.sv
// tb_sim_clock_scheduler
//   Directed bench for sim_clock_scheduler (N_OUT=4, DIV_W=16). The stimulus
//   pushes the expected per-cycle frames, which are written by hand as strings
//   indexed by RUN cycle. A negedge monitor pops each frame on its cycle and
//   compares it with the DUT outputs.
//   Honours SIM_CLOCK_SCHEDULER_CNT_EN for the ce_count port.
module tb_sim_clock_scheduler;

  logic        sys_clk = 1'b0;
  logic        sys_rst, cfg_we, start, stop;
  logic [1:0]  cfg_sel;
  logic [15:0] cfg_div, cfg_phase;
  logic        running, idle;
  logic [3:0]  ce_out, clk_out;
`ifdef SIM_CLOCK_SCHEDULER_CNT_EN
  logic [127:0] ce_count;
`endif

  sim_clock_scheduler #(.N_OUT(4), .DIV_W(16)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .cfg_we    (cfg_we),
    .cfg_sel   (cfg_sel),
    .cfg_div   (cfg_div),
    .cfg_phase (cfg_phase),
    .start     (start),
    .stop      (stop),
    .running   (running),
    .idle      (idle),
    .ce_out    (ce_out),
    .clk_out   (clk_out)
`ifdef SIM_CLOCK_SCHEDULER_CNT_EN
    ,
    .ce_count  (ce_count)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    int           cyc;
    int           kind;     // 0: outputs frame, 1: ce_count frame
    logic [3:0]   ce;
    logic [3:0]   clk;
    logic         idl;
    logic         run;
    logic [127:0] cnt;
    string        nm;
  } frame_t;

  frame_t q[$];
  int checks = 0;
  int errors = 0;

  // ---------------- monitor ----------------
  frame_t mf;
  always @(negedge sys_clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      mf = q.pop_front();
      checks++;
      if (mf.cyc < cyc) begin
        errors++;
        $display("FAIL %s: frame for cycle %0d not sampled (now %0d)", mf.nm, mf.cyc, cyc);
      end else if (mf.kind == 0) begin
        if (ce_out !== mf.ce || clk_out !== mf.clk || idle !== mf.idl || running !== mf.run) begin
          errors++;
          $display("FAIL %s: got ce=%b clk=%b idle=%b running=%b, expected ce=%b clk=%b idle=%b running=%b",
                   mf.nm, ce_out, clk_out, idle, running, mf.ce, mf.clk, mf.idl, mf.run);
        end
      end else begin
`ifdef SIM_CLOCK_SCHEDULER_CNT_EN
        if (ce_count !== mf.cnt) begin
          errors++;
          $display("FAIL %s: got ce_count=%h, expected %h", mf.nm, ce_count, mf.cnt);
        end
`endif
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic goto_cyc(input int c);
    while (cyc < c) step();
  endtask

  task automatic do_write(input int sel, input int div, input int ph);
    cfg_we    = 1'b1;
    cfg_sel   = 2'(sel);
    cfg_div   = 16'(div);
    cfg_phase = 16'(ph);
    step();
    cfg_we    = 1'b0;
  endtask

  function automatic logic bit_at(input string s, input int k);
    return s.substr(k, k) == "1";
  endfunction

  task automatic push_out(input int c, input logic [3:0] ce, input logic [3:0] clk,
                          input logic idl, input string nm);
    frame_t f;
    f.cyc = c; f.kind = 0; f.ce = ce; f.clk = clk;
    f.idl = idl; f.run = ~idl; f.cnt = '0; f.nm = nm;
    q.push_back(f);
  endtask

  task automatic push_cnt(input int c, input logic [127:0] cnt, input string nm);
    frame_t f;
    f.cyc = c; f.kind = 1; f.ce = '0; f.clk = '0;
    f.idl = 1'b0; f.run = 1'b0; f.cnt = cnt; f.nm = nm;
    q.push_back(f);
  endtask

  // Start is sampled in cycle s: IDLE in s, ARM in s+1, RUN cycle k in s+2+k.
  // ch2 and ch3 always share one config, so they share one pattern.
  task automatic push_run(input int s, input string nm,
                          input string ce0, input string ce1, input string ce23,
                          input string ck0, input string ck1, input string ck23,
                          input string idl);
    push_out(s,     4'b0000, 4'b0000, 1'b1, {nm, " idle"});
    push_out(s + 1, 4'b0000, 4'b0000, 1'b0, {nm, " arm"});
    for (int k = 0; k < idl.len(); k++)
      push_out(s + 2 + k,
               {bit_at(ce23, k), bit_at(ce23, k), bit_at(ce1, k), bit_at(ce0, k)},
               {bit_at(ck23, k), bit_at(ck23, k), bit_at(ck1, k), bit_at(ck0, k)},
               bit_at(idl, k), $sformatf("%s k%0d", nm, k));
  endtask

  // ---------------- stimulus ----------------
  int s;
  initial begin
    sys_rst = 1'b1; cfg_we = 1'b0; cfg_sel = '0; cfg_div = '0; cfg_phase = '0;
    start = 1'b0; stop = 1'b0;
    step(); step();
    push_out(cyc, 4'b0000, 4'b0000, 1'b1, "reset");
    sys_rst = 1'b0;
    step();

    // Run A: ch0 P=4, ch1 P=5 phi=2, ch2 div=0 -> P=2, ch3 default P=2.
    // ch0 is rewritten to div=8 at k5; stop is issued at k24.
    do_write(0, 4, 0);
    do_write(1, 5, 2);
    do_write(2, 0, 0);
    s = cyc; start = 1'b1;
    push_run(s, "runA",
             {"000100010000000100000001", "0000000100"},
             {"001000010000100001000010", "0001000000"},
             {"010101010101010101010101", "0100000000"},
             {"110011001111000011110000", "1111000000"},
             {"000110001100011000110001", "1000000000"},
             {"101010101010101010101010", "1000000000"},
             {"000000000000000000000000", "000000000", "1"});
    step(); start = 1'b0;
    goto_cyc(s + 7);  do_write(0, 8, 0);          // k5, mid-period
    goto_cyc(s + 26); stop = 1'b1; step(); stop = 1'b0;   // k24
    goto_cyc(s + 36);

    // Run B: start+stop together in IDLE, start in RUN, stop in RUN at k5,
    // stop again in STOP (k6) and start in STOP (k8).
    do_write(0, 4, 0);
    do_write(1, 5, 0);
    s = cyc; start = 1'b1; stop = 1'b1;
    push_run(s, "runB",
             "00010001000000", "00001000010000", "01010101000000",
             "11001100000000", "11000110000000", "10101010000000",
             "00000000000111");
`ifdef SIM_CLOCK_SCHEDULER_CNT_EN
    push_cnt(s + 15, {32'd4, 32'd4, 32'd2, 32'd2}, "runB ce_count held");
`endif
    step(); start = 1'b0; stop = 1'b0;
    goto_cyc(s + 4);  start = 1'b1; step(); start = 1'b0;  // k2 in RUN
    goto_cyc(s + 7);  stop  = 1'b1; step(); stop  = 1'b0;  // k5
    stop = 1'b1; step(); stop = 1'b0;                      // k6 in STOP
    goto_cyc(s + 10); start = 1'b1; step(); start = 1'b0;  // k8 in STOP
    goto_cyc(s + 16);

    // Run C: reset asserted during RUN at k3, so k4 shows reset values.
    s = cyc; start = 1'b1;
    push_run(s, "runC", "0001", "0000", "0101", "1100", "1100", "1010", "0000");
    push_out(s + 6, 4'b0000, 4'b0000, 1'b1, "runC reset");
`ifdef SIM_CLOCK_SCHEDULER_CNT_EN
    push_cnt(s + 6, '0, "runC ce_count reset");
`endif
    step(); start = 1'b0;
    goto_cyc(s + 5); sys_rst = 1'b1; step(); sys_rst = 1'b0;

    // Run D: configs back to P=2. ch1 div=3 phase=9 clamps to phi=2, which
    // puts its first ce on RUN cycle 0.
    do_write(1, 3, 9);
    s = cyc; start = 1'b1;
    push_run(s, "runD", "010101", "100100", "010101", "101010", "010010", "101010", "000000");
    step(); start = 1'b0;
    goto_cyc(s + 8);

    for (int i = 0; i < 20 && q.size() > 0; i++) step();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d frames left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
